tri_pwm_gen: RTL

- Center-aligned PWM generator that sits directly downstream of the triangle (bouncing up/down) counter. It consumes the counter's `cnt` sweep 0→2^W−1→0.
- Compares `cnt` against a double-buffered duty value and drives complementary gate outputs with programmable dead time.
- Duty updates arrive over a valid/ready handshake. They take effect only at the valley (`cnt == 0`), so no pulse is ever truncated.

---
 rtl/tri_pwm_gen_if.sv | 36 +++
 rtl/tri_pwm_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tri_pwm_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : tri_pwm_gen_if
// Description : Duty-update handshake bundle for tri_pwm_gen. The producer
//               (master) offers a duty value with duty_valid; the PWM block
//               (slave) takes it when duty_ready is high on the same edge.
// Ports       : duty_in    [WIDTH:0] requested compare threshold (0..2^WIDTH,
//                                    larger values saturate in the consumer)
//               duty_valid           duty_in is valid
//               duty_ready           consumer can hold one more pending value
// Revision    : 1.0 - initial release
// ============================================================================
interface tri_pwm_gen_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH:0] duty_in;
  logic           duty_valid;
  logic           duty_ready;

  // Producer side: drives the value and its qualifier, observes ready.
  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  // Consumer side: the PWM generator.
  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );

endinterface : tri_pwm_gen_if
`default_nettype wire

// File: rtl/tri_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : tri_pwm_gen
// Description : Center-aligned PWM generator fed by an up/down (triangle)
//               counter. The sampled count is compared against a
//               double-buffered duty value; the result drives a pair of
//               complementary gate outputs separated by a programmable
//               dead time. New duty values are taken over a valid/ready
//               handshake into a pending buffer and only become active at
//               the valley (cnt == 0), so a pulse is never cut short.
// Ports       : clk          clock, rising edge
//               rst_n        asynchronous active-low reset
//               en           gate enable; low forces both gates off
//               cnt          [WIDTH-1:0] triangle count
//               duty         duty handshake (tri_pwm_gen_if.slave)
//               pwm_h        high-side gate drive (registered)
//               pwm_l        low-side gate drive (registered)
//               valley_pulse one cycle, aligned with compare of cnt == 0
//               peak_pulse   one cycle, aligned with compare of cnt == max
// Revision    : 1.0 - initial release
// ============================================================================
module tri_pwm_gen #(
  parameter int WIDTH     = 4,
  parameter int DT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  cnt,
  tri_pwm_gen_if.slave      duty,
  output logic              pwm_h,
  output logic              pwm_l,
  output logic              valley_pulse,
  output logic              peak_pulse
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Full-scale duty (2^WIDTH) needs one extra bit above the count width so
  // that "always high" is expressible.
  localparam logic [WIDTH:0]   c_duty_max = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] c_cnt_peak = {WIDTH{1'b1}};

  // Dead-time counter only has to reach DT_CYCLES; keep at least one bit so
  // the DT_CYCLES == 0 build still has a legal vector.
  localparam int               c_dt_w     = (DT_CYCLES < 2) ? 1 : $clog2(DT_CYCLES + 1);
  localparam logic [c_dt_w-1:0] c_dt_max  = c_dt_w'(DT_CYCLES);
  localparam logic [c_dt_w-1:0] c_dt_one  = c_dt_w'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH:0]    r_duty_act;   // threshold used by the comparator
  logic [WIDTH:0]    r_duty_pend;  // buffered value waiting for the valley
  logic              r_pend_full;  // pending buffer holds a value
  logic              r_raw;        // registered compare result
  logic [c_dt_w-1:0] r_dt_cnt;     // cycles since the last raw edge (sat.)

  // --------------------------------------------------------------------------
  // Combinational next-state terms
  // --------------------------------------------------------------------------
  logic              w_valley;
  logic              w_peak;
  logic              w_accept;
  logic              w_xfer;
  logic [WIDTH:0]    w_duty_sat;
  logic [WIDTH:0]    w_eff;
  logic              w_raw_nxt;
  logic [c_dt_w-1:0] w_dt_nxt;
  logic              w_dt_done;

  always_comb begin
    w_valley   = 1'b0;
    w_peak     = 1'b0;
    w_accept   = 1'b0;
    w_xfer     = 1'b0;
    w_duty_sat = '0;
    w_eff      = '0;
    w_raw_nxt  = 1'b0;
    w_dt_nxt   = '0;
    w_dt_done  = 1'b0;

    w_valley = (cnt == '0);
    w_peak   = (cnt == c_cnt_peak);

    // Ready is simply "pending buffer empty", so an accept and a valley
    // transfer are mutually exclusive by construction.
    w_accept = duty.duty_valid && !r_pend_full;
    w_xfer   = w_valley && r_pend_full;

    // Anything beyond full scale behaves as full scale.
    w_duty_sat = (duty.duty_in > c_duty_max) ? c_duty_max : duty.duty_in;

    // On the transfer cycle the incoming value already governs this sample,
    // so the new duty starts exactly at the valley.
    w_eff = w_xfer ? r_duty_pend : r_duty_act;

    // Count zero-extended to WIDTH+1 so eff == 2^WIDTH is always true.
    w_raw_nxt = ({1'b0, cnt} < w_eff);

    // Restart dead time on every raw edge, otherwise count up and hold.
    if (w_raw_nxt != r_raw) begin
      w_dt_nxt = '0;
    end else if (r_dt_cnt == c_dt_max) begin
      w_dt_nxt = r_dt_cnt;
    end else begin
      w_dt_nxt = r_dt_cnt + c_dt_one;
    end

    // Gate outputs are decided from the same next values that load raw and
    // dt_cnt, so the outgoing gate drops in the same cycle raw flips and the
    // incoming gate rises DT_CYCLES later.
    w_dt_done = (w_dt_nxt == c_dt_max);
  end

  assign duty.duty_ready = !r_pend_full;

  // --------------------------------------------------------------------------
  // Duty double buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_act  <= '0;
      r_duty_pend <= '0;
      r_pend_full <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_duty_act  <= r_duty_pend;
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_duty_pend <= w_duty_sat;
        r_pend_full <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Compare, dead time and gate drive
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw        <= 1'b0;
      r_dt_cnt     <= '0;
      pwm_h        <= 1'b0;
      pwm_l        <= 1'b0;
      valley_pulse <= 1'b0;
      peak_pulse   <= 1'b0;
    end else begin
      r_raw        <= w_raw_nxt;
      r_dt_cnt     <= w_dt_nxt;
      // en gates only the drivers; compare and dead time keep running so
      // re-enabling lands on the correct phase.
      pwm_h        <= en &&  w_raw_nxt && w_dt_done;
      pwm_l        <= en && !w_raw_nxt && w_dt_done;
      valley_pulse <= w_valley;
      peak_pulse   <= w_peak;
    end
  end

endmodule : tri_pwm_gen
`default_nettype wire
